// File: rtl/sprinkler_pkg.sv
// Shared types and default constants for the sprinkler zone scheduler.
package sprinkler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_WATER,
    S_CLOSE,
    S_COOL,
    S_ALARM
  } state_e;

  localparam int DEF_NZONES   = 4;
  localparam int DEF_MAX_ON   = 16;
  localparam int DEF_COOLDOWN = 8;
  localparam int DEF_DEB_CYC  = 3;

endpackage

// File: rtl/sprinkler_rr_arbiter.sv
// Combinational round-robin pick: first requesting zone strictly after the pointer, wrapping.
module sprinkler_rr_arbiter
  import sprinkler_pkg::*;
#(
  parameter int NZONES = DEF_NZONES
) (
  input  logic [NZONES-1:0]         req,
  input  logic [$clog2(NZONES)-1:0] ptr,
  output logic [$clog2(NZONES)-1:0] gnt_idx,
  output logic                      gnt_valid
);

  localparam int ZW = $clog2(NZONES);

  int            k;
  logic [ZW-1:0] cand;

  // Offset 1 is checked first so the zone just served comes last.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    k         = 0;
    cand      = '0;
    for (int i = 1; i <= NZONES; i++) begin
      k    = (int'(ptr) + i) % NZONES;
      cand = ZW'(k);
      if (!gnt_valid && req[cand]) begin
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprinkler_zone_scheduler.sv
// Shares one pump between NZONES soil zones: round-robin grants, valve-before-pump, run cap, cooldown, dry-tank alarm.
// Build option: define SPRINKLER_DEBOUNCE_EN to synchronise and debounce the dry inputs.
module sprinkler_zone_scheduler
  import sprinkler_pkg::*;
#(
  parameter int NZONES   = DEF_NZONES,
  parameter int MAX_ON   = DEF_MAX_ON,
  parameter int COOLDOWN = DEF_COOLDOWN,
  parameter int DEB_CYC  = DEF_DEB_CYC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NZONES-1:0]         dry,
  input  logic                      water_ok,
  output logic                      relay,
  output logic [NZONES-1:0]         valve,
  output logic [$clog2(NZONES)-1:0] zone,
  output logic                      buzzer,
  output logic                      busy
);

  localparam int ZW = $clog2(NZONES);
  localparam int OW = $clog2(MAX_ON + 1);
  localparam int CW = $clog2(COOLDOWN + 1);

  logic [NZONES-1:0] dry_f;

`ifdef SPRINKLER_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYC + 1);

  // A filtered bit flips only after DEB_CYC consecutive synchronised samples disagree with it.
  for (genvar i = 0; i < NZONES; i++) begin : g_deb
    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;

    always_comb begin
      filt_d    = filt_q;
      deb_cnt_d = '0;
      if (sync2_q != filt_q) begin
        if (deb_cnt_q == DW'(DEB_CYC - 1)) filt_d = sync2_q;
        else                               deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        filt_q    <= 1'b0;
        deb_cnt_q <= '0;
      end else begin
        sync1_q   <= dry[i];
        sync2_q   <= sync1_q;
        filt_q    <= filt_d;
        deb_cnt_q <= deb_cnt_d;
      end
    end

    assign dry_f[i] = filt_q;
  end
`else
  // Without the filter DEB_CYC has no effect and the raw bits are used as-is.
  if (DEB_CYC > 0) begin : g_raw
    assign dry_f = dry;
  end else begin : g_raw_nodeb
    assign dry_f = dry;
  end
`endif

  state_e            state_q, state_d;
  logic [ZW-1:0]     ptr_q, ptr_d;
  logic [ZW-1:0]     grant_q, grant_d;
  logic [OW-1:0]     on_cnt_q, on_cnt_d;
  logic [CW-1:0]     cool_cnt_q, cool_cnt_d;
  logic              relay_q, relay_d;
  logic [NZONES-1:0] valve_q, valve_d;
  logic [ZW-1:0]     zone_q, zone_d;
  logic              buzzer_q, buzzer_d;
  logic              busy_q, busy_d;
  logic [ZW-1:0]     arb_idx;
  logic              arb_valid;

  sprinkler_rr_arbiter #(
    .NZONES (NZONES)
  ) u_arb (
    .req       (dry_f),
    .ptr       (ptr_q),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    on_cnt_d   = on_cnt_q;
    cool_cnt_d = cool_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          if (water_ok) begin
            state_d = S_OPEN;
            grant_d = arb_idx;
            ptr_d   = arb_idx;
          end else begin
            state_d = S_ALARM;
          end
        end
      end
      S_OPEN:  state_d = water_ok ? S_WATER : S_ALARM;
      S_WATER: begin
        if (!water_ok)                                                state_d = S_ALARM;
        else if (!dry_f[grant_q] || on_cnt_q == OW'(MAX_ON - 1))      state_d = S_CLOSE;
        else                                                          on_cnt_d = on_cnt_q + 1'b1;
      end
      S_CLOSE: state_d = S_COOL;
      S_COOL: begin
        if (cool_cnt_q == CW'(COOLDOWN)) state_d = S_IDLE;
        else                             cool_cnt_d = cool_cnt_q + 1'b1;
      end
      S_ALARM: if (water_ok) state_d = S_COOL;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      on_cnt_d   = '0;
      cool_cnt_d = '0;
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    relay_d  = (state_d == S_WATER);
    buzzer_d = (state_d == S_ALARM);
    busy_d   = (state_d != S_IDLE);
    valve_d  = '0;
    zone_d   = '0;
    if (state_d inside {S_OPEN, S_WATER, S_CLOSE}) begin
      valve_d[grant_d] = 1'b1;
      zone_d           = grant_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= ZW'(NZONES - 1);
      grant_q    <= '0;
      on_cnt_q   <= '0;
      cool_cnt_q <= '0;
      relay_q    <= 1'b0;
      valve_q    <= '0;
      zone_q     <= '0;
      buzzer_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      on_cnt_q   <= on_cnt_d;
      cool_cnt_q <= cool_cnt_d;
      relay_q    <= relay_d;
      valve_q    <= valve_d;
      zone_q     <= zone_d;
      buzzer_q   <= buzzer_d;
      busy_q     <= busy_d;
    end
  end

  assign relay  = relay_q;
  assign valve  = valve_q;
  assign zone   = zone_q;
  assign buzzer = buzzer_q;
  assign busy   = busy_q;

endmodule
